cr16_fib_ctrl: RTL

CR16_FIB_CTRL -- requirements
Module: cr16_fib_ctrl

---
 rtl/cr16_fib_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/cr16_fib_ctrl.sv
// cr16_fib_ctrl: sequencer that drives a 16-register datapath through a
// clear / seed / Fibonacci-add run, shadow-checking every ALU result.
module cr16_fib_ctrl (
    input  logic        I_CLK,
    input  logic        I_RESET,
    input  logic        I_START,
    input  logic [3:0]  I_COUNT,
    input  logic [15:0] I_SEED_A,
    input  logic [15:0] I_SEED_B,
    input  logic [15:0] I_WRITE_PORT,
    output logic [15:0] O_REG_ENABLE,
    output logic [3:0]  O_OPCODE,
    output logic        O_ENABLE,
    output logic [3:0]  O_READ_PORT_A_SEL,
    output logic [3:0]  O_READ_PORT_B_SEL,
    output logic [15:0] O_IMMEDIATE,
    output logic        O_IMM_SEL,
    output logic        O_BUSY,
    output logic        O_DONE,
    output logic [15:0] O_LAST,
    output logic        O_OVERFLOW,
    output logic        O_ERR
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_SEED0 = 3'd2;
    localparam logic [2:0] S_SEED1 = 3'd3;
    localparam logic [2:0] S_ADD   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [3:0]  k_q, k_d;
    logic [3:0]  n_q;
    logic [15:0] seed_a_q, seed_b_q;
    logic [15:0] p_q, q_q;

    logic [15:0] reg_en_q, reg_en_d;
    logic [3:0]  a_sel_q, a_sel_d;
    logic [3:0]  b_sel_q, b_sel_d;
    logic [15:0] imm_q, imm_d;
    logic        imm_sel_q, imm_sel_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] last_q;
    logic        ovf_q, err_q;

    logic [3:0]  n_clamp;
    logic [3:0]  add_dst;
    logic [16:0] sum;

    // Counts above 14 would run the destination index past r15.
    assign n_clamp = (I_COUNT == 4'd15) ? 4'd14 : I_COUNT;
    assign add_dst = k_d + 4'd2;
    assign sum     = {1'b0, p_q} + {1'b0, q_q};

    assign O_REG_ENABLE      = reg_en_q;
    assign O_OPCODE          = 4'b0000;
    assign O_ENABLE          = 1'b1;
    assign O_READ_PORT_A_SEL = a_sel_q;
    assign O_READ_PORT_B_SEL = b_sel_q;
    assign O_IMMEDIATE       = imm_q;
    assign O_IMM_SEL         = imm_sel_q;
    assign O_BUSY            = busy_q;
    assign O_DONE            = done_q;
    assign O_LAST            = last_q;
    assign O_OVERFLOW        = ovf_q;
    assign O_ERR             = err_q;

    // Next state and step index.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE: begin
                if (I_START) begin
                    state_d = S_CLEAR;
                    k_d     = 4'd0;
                end
            end
            S_CLEAR: begin
                if (k_q == 4'd15) begin
                    state_d = S_SEED0;
                    k_d     = 4'd0;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            S_SEED0: state_d = S_SEED1;
            S_SEED1: begin
                state_d = (n_q == 4'd0) ? S_DONE : S_ADD;
                k_d     = 4'd0;
            end
            S_ADD: begin
                if (k_q == n_q - 4'd1) begin
                    state_d = S_DONE;
                    k_d     = 4'd0;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                k_d     = 4'd0;
            end
            default: begin
                state_d = S_IDLE;
                k_d     = 4'd0;
            end
        endcase
    end

    // Datapath controls decoded from the upcoming state so they leave flops.
    always_comb begin
        reg_en_d  = 16'h0000;
        a_sel_d   = 4'd0;
        b_sel_d   = 4'd1;
        imm_d     = 16'h0000;
        imm_sel_d = 1'b1;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        case (state_d)
            S_CLEAR: begin
                reg_en_d = 16'h0001 << k_d;
                busy_d   = 1'b1;
            end
            S_SEED0: begin
                reg_en_d = 16'h0001;
                imm_d    = seed_a_q;
                busy_d   = 1'b1;
            end
            S_SEED1: begin
                reg_en_d = 16'h0002;
                imm_d    = seed_b_q;
                busy_d   = 1'b1;
            end
            S_ADD: begin
                reg_en_d  = 16'h0001 << add_dst;
                a_sel_d   = k_d;
                b_sel_d   = k_d + 4'd1;
                imm_sel_d = 1'b0;
                busy_d    = 1'b1;
            end
            S_DONE: done_d = 1'b1;
            default: ;
        endcase
    end

    // State, output flops, shadow Fibonacci pair and sticky status.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state_q   <= S_IDLE;
            k_q       <= 4'd0;
            n_q       <= 4'd0;
            seed_a_q  <= 16'h0000;
            seed_b_q  <= 16'h0000;
            p_q       <= 16'h0000;
            q_q       <= 16'h0000;
            reg_en_q  <= 16'h0000;
            a_sel_q   <= 4'd0;
            b_sel_q   <= 4'd1;
            imm_q     <= 16'h0000;
            imm_sel_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            last_q    <= 16'h0000;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            reg_en_q  <= reg_en_d;
            a_sel_q   <= a_sel_d;
            b_sel_q   <= b_sel_d;
            imm_q     <= imm_d;
            imm_sel_q <= imm_sel_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            case (state_q)
                S_IDLE: begin
                    if (I_START) begin
                        seed_a_q <= I_SEED_A;
                        seed_b_q <= I_SEED_B;
                        n_q      <= n_clamp;
                        ovf_q    <= 1'b0;
                        err_q    <= 1'b0;
                    end
                end
                S_CLEAR: last_q <= 16'h0000;
                S_SEED0: begin
                    last_q <= seed_a_q;
                    p_q    <= seed_a_q;
                end
                S_SEED1: begin
                    last_q <= seed_b_q;
                    q_q    <= seed_b_q;
                end
                S_ADD: begin
                    // The ALU result is written this edge; check it against the shadow sum.
                    last_q <= I_WRITE_PORT;
                    p_q    <= q_q;
                    q_q    <= sum[15:0];
                    if (sum[16])
                        ovf_q <= 1'b1;
                    if (I_WRITE_PORT != sum[15:0])
                        err_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
